// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: memory-port arbiter states, requester ids and default memory latency.
package mips_pkg;

    localparam int unsigned MEM_LAT_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between IF and MEM; one fixed-latency access at a time.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed D-over-I priority.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [DATA_W-1:0] iRdata,
    output logic              iValid,
    input  logic              dReq,
    input  logic              dWe,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic [DATA_W-1:0] dRdata,
    output logic              dValid,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic              ifStall,
    output logic              memStall
);

    localparam int unsigned CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    arb_state_t        r_state;
    arb_state_t        w_next;
    owner_t            r_owner;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_memEn;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_iRdata;
    logic [DATA_W-1:0] r_dRdata;
    logic              r_iValid;
    logic              r_dValid;
    logic              w_req;
    logic              w_grantD;

    // r_owner holds the most recent grant, so it also serves as the round-robin history.
    always_comb begin
        w_req = iReq | dReq;
`ifdef MEM_ARB_RR_EN
        w_grantD = dReq & (~iReq | (r_owner == OWN_I));
`else
        w_grantD = dReq;
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_cnt == '0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_owner    <= OWN_I;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_iRdata   <= '0;
            r_dRdata   <= '0;
            r_iValid   <= 1'b0;
            r_dValid   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_memEn  <= 1'b0;
            r_memWe  <= 1'b0;
            r_iValid <= 1'b0;
            r_dValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Strobes are registered one cycle early so they line up with ISSUE.
                    if (w_req) begin
                        r_memEn <= 1'b1;
                        if (w_grantD) begin
                            r_owner    <= OWN_D;
                            r_we       <= dWe;
                            r_memWe    <= dWe;
                            r_memAddr  <= dAddr;
                            r_memWdata <= dWdata;
                        end else begin
                            r_owner   <= OWN_I;
                            r_we      <= 1'b0;
                            r_memAddr <= iAddr;
                        end
                    end
                end
                ISSUE: r_cnt <= CNT_W'(MEM_LAT - 1);
                WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_owner == OWN_I) begin
                        r_iRdata <= memRdata;
                        r_iValid <= 1'b1;
                    end else begin
                        r_dValid <= 1'b1;
                        if (!r_we) r_dRdata <= memRdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign memEn    = r_memEn;
    assign memWe    = r_memWe;
    assign memAddr  = r_memAddr;
    assign memWdata = r_memWdata;
    assign iRdata   = r_iRdata;
    assign dRdata   = r_dRdata;
    assign iValid   = r_iValid;
    assign dValid   = r_dValid;
    assign ifStall  = iReq & ~r_iValid;
    assign memStall = dReq & ~r_dValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LAT=2, instance 1 uses MEM_LAT=1.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [1:0]  dut;
        logic [15:0] cyc;
        logic [1:0]  kind;   // 0 read issue, 1 write issue, 2 iValid, 3 dValid
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    ev_t         obs_q[$];

    logic        iReq[2], iValid[2], dReq[2], dWe[2], dValid[2];
    logic        memEn[2], memWe[2], ifStall[2], memStall[2];
    logic [31:0] iAddr[2], iRdata[2], dAddr[2], dWdata[2], dRdata[2];
    logic [31:0] memAddr[2], memWdata[2], memRdata[2];
    logic [31:0] p0a = '1, p0b = '1, p1a = '1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut0 (
        .clk(clk), .rst(rst),
        .iReq(iReq[0]), .iAddr(iAddr[0]), .iRdata(iRdata[0]), .iValid(iValid[0]),
        .dReq(dReq[0]), .dWe(dWe[0]), .dAddr(dAddr[0]), .dWdata(dWdata[0]),
        .dRdata(dRdata[0]), .dValid(dValid[0]),
        .memEn(memEn[0]), .memWe(memWe[0]), .memAddr(memAddr[0]), .memWdata(memWdata[0]),
        .memRdata(memRdata[0]), .ifStall(ifStall[0]), .memStall(memStall[0])
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .iReq(iReq[1]), .iAddr(iAddr[1]), .iRdata(iRdata[1]), .iValid(iValid[1]),
        .dReq(dReq[1]), .dWe(dWe[1]), .dAddr(dAddr[1]), .dWdata(dWdata[1]),
        .dRdata(dRdata[1]), .dValid(dValid[1]),
        .memEn(memEn[1]), .memWe(memWe[1]), .memAddr(memAddr[1]), .memWdata(memWdata[1]),
        .memRdata(memRdata[1]), .ifStall(ifStall[1]), .memStall(memStall[1])
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C22_0004;
        if (a == 32'hFFFF_FFFF) return 32'hBAD0_BAD0;
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic ev_t mk(input int d, input int c, input int k,
                               input logic [31:0] a, input logic [31:0] dt);
        ev_t e;
        e.dut  = d[1:0];
        e.cyc  = c[15:0];
        e.kind = k[1:0];
        e.addr = a;
        e.data = dt;
        return e;
    endfunction

    function automatic logic [131:0] outs(input int k);
        return {memEn[k], memWe[k], memAddr[k], memWdata[k], iRdata[k], dRdata[k],
                iValid[k], dValid[k]};
    endfunction

    // Memory model: data appears exactly MEM_LAT cycles after the issue cycle, garbage otherwise.
    always @(posedge clk) begin
        p0a <= memEn[0] ? memAddr[0] : '1;
        p0b <= p0a;
        p1a <= memEn[1] ? memAddr[1] : '1;
    end
    always_comb begin
        memRdata[0] = mem_data(p0b);
        memRdata[1] = mem_data(p1a);
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (memEn[k])
                obs_q.push_back(mk(k, cyc, memWe[k] ? 1 : 0, memAddr[k],
                                   memWe[k] ? memWdata[k] : 32'h0));
            if (iValid[k]) obs_q.push_back(mk(k, cyc, 2, 32'h0, iRdata[k]));
            if (dValid[k]) obs_q.push_back(mk(k, cyc, 3, 32'h0, dRdata[k]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iReq[k] = 0; dReq[k] = 0; dWe[k] = 0;
            iAddr[k] = '0; dAddr[k] = '0; dWdata[k] = '0;
        end
        step(3);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (outs(k) !== '0) begin
                errors++;
                $display("FAIL reset_outs dut%0d got %h exp 0", k, outs(k));
            end
        end
        rst = 1'b1;
        step(2);
        obs_q.delete();
    endtask

    task automatic test_reset_abort;
        ev_t e, o;
        int t = cyc;
        iReq[0] = 1; iAddr[0] = 32'h60;
        exp_q.push_back(mk(0, t + 1, 0, 32'h60, 32'h0));
        step(2);
        rst = 1'b0; iReq[0] = 0;
        step(2);
        rst = 1'b1;
        checks++;
        if (outs(0) !== '0) begin
            errors++;
            $display("FAIL abort_outs got %h exp 0", outs(0));
        end
        step(6);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL abort_ev got %h exp %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL abort_extra got %0d events exp 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_fetch;
        ev_t e, o;
        int t = cyc;
        iReq[0] = 1; iAddr[0] = 32'h40;
        exp_q.push_back(mk(0, t + 1, 0, 32'h40, 32'h0));
        exp_q.push_back(mk(0, t + 4, 2, 32'h0, 32'h8C22_0004));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (ifStall[0] !== (k < 4)) begin
                errors++;
                $display("FAIL fetch_stall T+%0d got %b exp %b", k, ifStall[0], k < 4);
            end
        end
        @(posedge clk); #1;
        iReq[0] = 0;
        step(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL fetch_ev got %h exp %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL fetch_extra got %0d events exp 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    // Store, load, store on instance 1; dReq is held through dValid and dropped the cycle after.
    task automatic test_back_to_back;
        ev_t e, o;
        int t;
        logic        we[3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] ad[3] = '{32'h100, 32'h200, 32'h104};
        logic [31:0] wd[3] = '{32'hDEAD_BEEF, 32'h0, 32'h1234_5678};
        logic [31:0] last_ld = 32'h0;
        for (int n = 0; n < 3; n++) begin
            t = cyc;
            dReq[1] = 1; dWe[1] = we[n]; dAddr[1] = ad[n]; dWdata[1] = wd[n];
            exp_q.push_back(mk(1, t + 1, we[n] ? 1 : 0, ad[n], we[n] ? wd[n] : 32'h0));
            if (!we[n]) last_ld = mem_data(ad[n]);
            exp_q.push_back(mk(1, t + 3, 3, 32'h0, last_ld));
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                checks++;
                if (memStall[1] !== (k < 3)) begin
                    errors++;
                    $display("FAIL data_stall op%0d T+%0d got %b exp %b", n, k, memStall[1], k < 3);
                end
            end
            @(posedge clk); #1;
            dReq[1] = 0;
            step(2);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL data_ev got %h exp %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL data_extra got %0d events exp 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_drop_midflight;
        ev_t e, o;
        int t = cyc;
        iReq[0] = 1; iAddr[0] = 32'h80;
        exp_q.push_back(mk(0, t + 1, 0, 32'h80, 32'h0));
        exp_q.push_back(mk(0, t + 4, 2, 32'h0, mem_data(32'h80)));
        step(2);
        iReq[0] = 0;
        step(4);
        iReq[0] = 1; iAddr[0] = 32'h84;
        exp_q.push_back(mk(0, t + 7, 0, 32'h84, 32'h0));
        exp_q.push_back(mk(0, t + 10, 2, 32'h0, mem_data(32'h84)));
        step(4);
        iReq[0] = 0;
        step(3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL drop_ev got %h exp %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL drop_extra got %0d events exp 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_tie;
        ev_t e, o;
        int t;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
        obs_q.delete();
        t = cyc;
        dReq[1] = 1; dWe[1] = 0; dAddr[1] = 32'h300;
        iReq[1] = 1; iAddr[1] = 32'h44;
`ifdef MEM_ARB_RR_EN
        for (int g = 0; g < 4; g++) begin
            if (g % 2 == 0) begin
                exp_q.push_back(mk(1, t + 4 * g + 1, 0, 32'h300, 32'h0));
                exp_q.push_back(mk(1, t + 4 * g + 3, 3, 32'h0, mem_data(32'h300)));
            end else begin
                exp_q.push_back(mk(1, t + 4 * g + 1, 0, 32'h44, 32'h0));
                exp_q.push_back(mk(1, t + 4 * g + 3, 2, 32'h0, mem_data(32'h44)));
            end
        end
        step(15);
        dReq[1] = 0; iReq[1] = 0;
        step(3);
`else
        exp_q.push_back(mk(1, t + 1, 0, 32'h300, 32'h0));
        exp_q.push_back(mk(1, t + 3, 3, 32'h0, mem_data(32'h300)));
        exp_q.push_back(mk(1, t + 5, 0, 32'h44, 32'h0));
        exp_q.push_back(mk(1, t + 7, 2, 32'h0, mem_data(32'h44)));
        step(4);
        dReq[1] = 0;
        step(3);
        iReq[1] = 0;
        step(3);
`endif
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '1;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin errors++; $display("FAIL tie_ev got %h exp %h", o, e); end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL tie_extra got %0d events exp 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset;
        test_reset_abort;
        test_fetch;
        test_back_to_back;
        test_drop_midflight;
        test_tie;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch stage and the MEM stage (lw/sw) of the MIPS pipeline. It sequences each access through a fixed-latency memory, returns read data or a write acknowledge to the owning requester, and produces the per-stage stall signals the pipeline uses to freeze IF or MEM while the port is busy.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from issue cycle to memRdata valid; legal range 1..15
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- iReq  in  1  fetch request, level, held until iValid
- iAddr  in  ADDR_W  fetch address
- iRdata  out  DATA_W  fetched instruction
- iValid  out  1  one-cycle completion pulse for fetch
- dReq  in  1  data request, level, held until dValid
- dWe  in  1  1 = store, 0 = load
- dAddr  in  ADDR_W  data address
- dWdata  in  DATA_W  store data
- dRdata  out  DATA_W  load data
- dValid  out  1  one-cycle completion pulse for load or store
- memEn  out  1  memory access strobe, high only in the issue cycle
- memWe  out  1  memory write enable, qualified by memEn
- memAddr  out  ADDR_W  memory address
- memWdata  out  DATA_W  memory write data
- memRdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the issue cycle
- ifStall  out  1  iReq & ~iValid
- memStall  out  1  dReq & ~dValid

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - With no request pending, stay in IDLE.
  - With a request pending, latch the owner (I or D), address, dWe and dWdata, then go to ISSUE.
  - When only one request is pending, that requester wins.
- ISSUE: memEn=1; memWe=latched we (0 for fetch); memAddr and memWdata come from the latched registers. Load the counter with MEM_LAT-1 and go to WAIT.
- WAIT: when the counter reaches 0, capture memRdata into the owner's rdata register and go to RESP. Otherwise decrement the counter.
- RESP:
  - Pulse the owner's Valid for exactly one cycle, then go to IDLE.
  - Stores pulse dValid with dRdata unchanged.
- Requester inputs are sampled only in IDLE. Changes after the grant are ignored.
- A request dropped mid-flight still completes and still pulses Valid; the requester ignores that pulse.
- The owner's request is still high during RESP. Because the FSM is in RESP that cycle, no second grant occurs. IDLE resamples in the following cycle.
- The counter is $clog2(MEM_LAT+1) bits wide. MEM_LAT=0 is illegal and must be flagged by an elaboration assertion.
- Stall outputs are combinational. All other outputs are registered.

## Timing
- Reset value of every output is 0: memEn, memWe, memAddr, memWdata, iRdata, dRdata, iValid and dValid. The FSM resets to IDLE, the counter to 0, and lastOwner to I.
- Reset asserted mid-access aborts the access:
  - no Valid pulse;
  - memEn low from the first reset cycle.
- Request seen in IDLE at cycle T:
  - ISSUE at T+1;
  - WAIT from T+2 to T+1+MEM_LAT;
  - RESP (Valid) at T+2+MEM_LAT.
- Earliest next grant is evaluated at T+3+MEM_LAT. Throughput is one access per MEM_LAT+3 cycles.
- Stalls: ifStall/memStall are high from the request cycle through the cycle before Valid, and low in the Valid cycle.

## Configuration
- MEM_ARB_RR_EN undefined: fixed priority; dReq wins every tie in IDLE because the MEM-stage instruction is older.
- MEM_ARB_RR_EN defined: a lastOwner register is updated at each grant. On a tie, the requester that was not granted last wins. lastOwner resets to I, so the first tie goes to D.

## Structure
- Shared package mips_pkg holds:
  - typedef enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - typedef enum owner_t {OWN_I, OWN_D};
  - the default MEM_LAT constant.
- No sub-module; the counter and FSM live in a single module.

## Test plan
- Reset: rst=0 for 2 cycles during WAIT -> all outputs 0 the next cycle, no Valid pulse, FSM in IDLE.
- Fetch with MEM_LAT=2: iReq, iAddr=0x40 at T; memRdata=0x8C220004 at T+3 ->
  - memEn=1, memWe=0, memAddr=0x40 at T+1;
  - iValid=1, iRdata=0x8C220004 at T+4;
  - ifStall high T..T+3.
- Store with MEM_LAT=1: dReq, dWe=1, dAddr=0x100, dWdata=0xDEADBEEF at T ->
  - memEn=memWe=1, memWdata=0xDEADBEEF at T+1;
  - dValid at T+3.
- Tie, both requests held, MEM_LAT=1:
  - without MEM_ARB_RR_EN -> D is granted first and I is issued at T+5;
  - with MEM_ARB_RR_EN and both requests re-asserted continuously -> grants alternate D, I, D, I.
- No double grant: requester holds dReq through the dValid cycle and drops it the cycle after -> exactly one memEn pulse.
- iReq dropped at T+2 during WAIT -> access completes, iValid still pulses at T+2+MEM_LAT, FSM returns to IDLE.
